// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the decode/execute boundary of the pipeline.
// Contents:
//   - default field widths, common with unit_control
//   - the bubble fill value (a bubble is every field zero)
//   - the halt-drain FSM state encoding
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int NB_PC       = 32;
  localparam int NB_DATA     = 32;
  localparam int NB_REG      = 5;
  localparam int NB_EX_CTRL  = 7;
  localparam int NB_MEM_CTRL = 6;
  localparam int NB_WB_CTRL  = 3;

  // Replicated across every field of the register bank to form a bubble.
  // Keeping it a single bit lets the bank stay parameterised in width.
  localparam logic BUBBLE_FILL = 1'b0;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } drain_state_e;

endpackage

// File: rtl/halt_drain_fsm.sv
// ---------------------------------------------------------------------------
// halt_drain_fsm
// Tracks HALT through the back end of the pipeline. Once a HALT reaches the
// decode/execute boundary, the instructions already in EX/MEM/WB must retire.
// After that the pipeline reports itself halted. It also tells the register
// bank when to load a bubble instead of the decode-stage instruction.
// Ports:
//   i_clock          rising-edge clock
//   i_reset          asynchronous active-high reset
//   i_enable         advance this cycle; 0 freezes state and counter
//   i_flush          squash the decode-stage instruction
//   i_halt_detected  decode-stage instruction is HALT
//   o_bubble         bank should load a bubble on the next enabled edge
//   o_halt_pending   drain in progress or halted
//   o_halted         every instruction older than HALT has retired
// ---------------------------------------------------------------------------
module halt_drain_fsm
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_flush,
  input  logic i_halt_detected,
  output logic o_bubble,
  output logic o_halt_pending,
  output logic o_halted
);

  // The counter holds the number of further enabled edges to spend in DRAIN
  // after the current one. That makes HALTED arrive DRAIN_CYCLES edges after
  // the capture edge.
  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  drain_state_e state_q, state_d;
  logic [1:0]   count_q, count_d;

  // State and drain counter; reset forces RUN immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state. Nothing moves while disabled. Flush outranks HALT, so a
  // squashed HALT never starts a drain. The counter is only loaded in RUN
  // and only decremented in DRAIN, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (i_enable) begin
      unique case (state_q)
        RUN: begin
          if (!i_flush && i_halt_detected) begin
            state_d = DRAIN;
            count_d = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (count_q == 2'd0) begin
            state_d = HALTED;
          end else begin
            count_d = count_q - 2'd1;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
          count_d = 2'd0;
        end
      endcase
    end
  end

  // The bubble request depends on the inputs: the bank needs it on the same
  // edge as the flush or HALT. The status flags come only from the state
  // register.
  always_comb begin
    o_bubble       = (state_q != RUN) || i_flush || i_halt_detected;
    o_halt_pending = (state_q != RUN);
    o_halted       = (state_q == HALTED);
  end

endmodule

// File: rtl/id_ex_latch.sv
// ---------------------------------------------------------------------------
// id_ex_latch
// Pipeline register between decode and execute. On every enabled edge it
// captures the EX/MEM/WB control bundles, operands, immediate, register
// indices and PC+4. A bubble (all zeros) replaces the instruction on flush,
// on HALT, and for the whole drain/halted period.
// Ports:
//   i_clock, i_reset          rising-edge clock, asynchronous active-high reset
//   i_enable                  advance the pipeline; 0 holds everything
//   i_flush                   squash the decode-stage instruction
//   i_halt_detected           decode-stage instruction is HALT
//   i_EX/M/WB_control         control bundles from unit_control
//   i_pc                      PC+4 of the decode-stage instruction
//   i_data_a/b, i_immediate   operands and extended immediate
//   i_rs/rt/rd/shamt          instruction fields
//   o_*                       registered copies of the above
//   o_halt_pending, o_halted  halt-drain status for the debug unit
// ---------------------------------------------------------------------------
module id_ex_latch
  import pipeline_pkg::*;
#(
  parameter int NB_PC        = pipeline_pkg::NB_PC,
  parameter int NB_DATA      = pipeline_pkg::NB_DATA,
  parameter int NB_REG       = pipeline_pkg::NB_REG,
  parameter int NB_EX_CTRL   = pipeline_pkg::NB_EX_CTRL,
  parameter int NB_MEM_CTRL  = pipeline_pkg::NB_MEM_CTRL,
  parameter int NB_WB_CTRL   = pipeline_pkg::NB_WB_CTRL,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic [NB_EX_CTRL-1:0]  i_EX_control,
  input  logic [NB_MEM_CTRL-1:0] i_M_control,
  input  logic [NB_WB_CTRL-1:0]  i_WB_control,
  input  logic                   i_halt_detected,
  input  logic [NB_PC-1:0]       i_pc,
  input  logic [NB_DATA-1:0]     i_data_a,
  input  logic [NB_DATA-1:0]     i_data_b,
  input  logic [NB_DATA-1:0]     i_immediate,
  input  logic [NB_REG-1:0]      i_rs,
  input  logic [NB_REG-1:0]      i_rt,
  input  logic [NB_REG-1:0]      i_rd,
  input  logic [NB_REG-1:0]      i_shamt,
  output logic [NB_EX_CTRL-1:0]  o_EX_control,
  output logic [NB_MEM_CTRL-1:0] o_M_control,
  output logic [NB_WB_CTRL-1:0]  o_WB_control,
  output logic [NB_PC-1:0]       o_pc,
  output logic [NB_DATA-1:0]     o_data_a,
  output logic [NB_DATA-1:0]     o_data_b,
  output logic [NB_DATA-1:0]     o_immediate,
  output logic [NB_REG-1:0]      o_rs,
  output logic [NB_REG-1:0]      o_rt,
  output logic [NB_REG-1:0]      o_rd,
  output logic [NB_REG-1:0]      o_shamt,
  output logic                   o_halt_pending,
  output logic                   o_halted
);

  // All captured fields travel as one flat vector. This keeps the bubble
  // mux and the register a single statement each.
  localparam int NB_BANK = NB_EX_CTRL + NB_MEM_CTRL + NB_WB_CTRL + NB_PC
                         + 3 * NB_DATA + 4 * NB_REG;

  logic               bubble;
  logic [NB_BANK-1:0] bank_in;
  logic [NB_BANK-1:0] bank_d;
  logic [NB_BANK-1:0] bank_q;

  halt_drain_fsm #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_halt_drain_fsm (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_flush         (i_flush),
    .i_halt_detected (i_halt_detected),
    .o_bubble        (bubble),
    .o_halt_pending  (o_halt_pending),
    .o_halted        (o_halted)
  );

  assign bank_in = {i_EX_control, i_M_control, i_WB_control, i_pc,
                    i_data_a, i_data_b, i_immediate,
                    i_rs, i_rt, i_rd, i_shamt};

  // A bubble replaces the instruction while a flush, HALT, drain or halt is
  // in effect.
  always_comb begin
    bank_d = bank_in;
    if (bubble) begin
      bank_d = {NB_BANK{BUBBLE_FILL}};
    end
  end

  // The bank only advances on enabled edges. Reset clears it immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bank_q <= {NB_BANK{BUBBLE_FILL}};
    end else if (i_enable) begin
      bank_q <= bank_d;
    end
  end

  assign {o_EX_control, o_M_control, o_WB_control, o_pc,
          o_data_a, o_data_b, o_immediate,
          o_rs, o_rt, o_rd, o_shamt} = bank_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// ---------------------------------------------------------------------------
// tb_id_ex_latch
// Self-checking bench for id_ex_latch with default widths and DRAIN_CYCLES=3.
// ---------------------------------------------------------------------------
module tb_id_ex_latch;

  localparam int DRAIN = 3;

  typedef struct packed {
    logic        en;
    logic        fl;
    logic        ht;
    logic [6:0]  ex;
    logic [5:0]  m;
    logic [2:0]  wb;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
  } in_t;

  typedef struct packed {
    logic [6:0]  ex;
    logic [5:0]  m;
    logic [2:0]  wb;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic        pend;
    logic        hlt;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        i_clock;
  logic        i_reset;
  logic        i_enable;
  logic        i_flush;
  logic        i_halt_detected;
  logic [6:0]  i_EX_control, o_EX_control;
  logic [5:0]  i_M_control, o_M_control;
  logic [2:0]  i_WB_control, o_WB_control;
  logic [31:0] i_pc, o_pc;
  logic [31:0] i_data_a, o_data_a;
  logic [31:0] i_data_b, o_data_b;
  logic [31:0] i_immediate, o_immediate;
  logic [4:0]  i_rs, o_rs, i_rt, o_rt, i_rd, o_rd, i_shamt, o_shamt;
  logic        o_halt_pending;
  logic        o_halted;

  int checks = 0;
  int fails  = 0;

  // Reference model state: last bank contents plus drain bookkeeping.
  out_t mdl;
  bit   mPend;
  bit   mHalt;
  int   drainLeft;

  id_ex_latch #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_flush         (i_flush),
    .i_EX_control    (i_EX_control),
    .i_M_control     (i_M_control),
    .i_WB_control    (i_WB_control),
    .i_halt_detected (i_halt_detected),
    .i_pc            (i_pc),
    .i_data_a        (i_data_a),
    .i_data_b        (i_data_b),
    .i_immediate     (i_immediate),
    .i_rs            (i_rs),
    .i_rt            (i_rt),
    .i_rd            (i_rd),
    .i_shamt         (i_shamt),
    .o_EX_control    (o_EX_control),
    .o_M_control     (o_M_control),
    .o_WB_control    (o_WB_control),
    .o_pc            (o_pc),
    .o_data_a        (o_data_a),
    .o_data_b        (o_data_b),
    .o_immediate     (o_immediate),
    .o_rs            (o_rs),
    .o_rt            (o_rt),
    .o_rd            (o_rd),
    .o_shamt         (o_shamt),
    .o_halt_pending  (o_halt_pending),
    .o_halted        (o_halted)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic in_t mkIn(logic en, logic fl, logic ht, logic [6:0] ex,
                               logic [5:0] m, logic [2:0] wb, logic [31:0] a,
                               logic [4:0] rd);
    in_t r;
    r.en  = en;   r.fl = fl;  r.ht = ht;
    r.ex  = ex;   r.m  = m;   r.wb = wb;
    r.a   = a;    r.rd = rd;
    r.pc  = a + 32'h400;
    r.b   = ~a;
    r.imm = a ^ 32'hFFFF_0000;
    r.rs  = rd + 5'd1;
    r.rt  = rd + 5'd2;
    r.sh  = rd ^ 5'h1F;
    return r;
  endfunction

  function automatic out_t expOf(in_t s, bit cap, bit p, bit h);
    out_t o = '0;
    if (cap) begin
      o.ex = s.ex;  o.m  = s.m;  o.wb = s.wb;  o.pc = s.pc;
      o.a  = s.a;   o.b  = s.b;  o.imm = s.imm;
      o.rs = s.rs;  o.rt = s.rt; o.rd = s.rd;  o.sh = s.sh;
    end
    o.pend = p;
    o.hlt  = h;
    return o;
  endfunction

  function automatic in_t randIn();
    in_t r;
    r.en  = ($urandom_range(0, 3) != 0);
    r.fl  = ($urandom_range(0, 7) == 0);
    r.ht  = ($urandom_range(0, 15) == 0);
    r.ex  = 7'($urandom);  r.m  = 6'($urandom);  r.wb = 3'($urandom);
    r.pc  = $urandom;      r.a  = $urandom;      r.b  = $urandom;
    r.imm = $urandom;
    r.rs  = 5'($urandom);  r.rt = 5'($urandom);
    r.rd  = 5'($urandom);  r.sh = 5'($urandom);
    return r;
  endfunction

  // Behavioural model: a HALT starts a countdown of DRAIN enabled edges,
  // after which the pipeline is halted for good. Anything other than a clean
  // RUN capture leaves a bubble.
  task automatic modelEdge(in_t v);
    if (!v.en) return;
    if (mHalt) begin
      mdl = expOf(v, 0, 1, 1);
    end else if (mPend) begin
      drainLeft = drainLeft - 1;
      if (drainLeft == 0) mHalt = 1;
      mdl = expOf(v, 0, 1, mHalt);
    end else if (v.fl) begin
      mdl = expOf(v, 0, 0, 0);
    end else if (v.ht) begin
      mPend = 1;
      drainLeft = DRAIN;
      mdl = expOf(v, 0, 1, 0);
    end else begin
      mdl = expOf(v, 1, 0, 0);
    end
  endtask

  task automatic modelReset();
    mdl = '0;
    mPend = 0;
    mHalt = 0;
    drainLeft = 0;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, out_t e);
    cmp({tag, ".ex"},   32'(o_EX_control),   32'(e.ex));
    cmp({tag, ".m"},    32'(o_M_control),    32'(e.m));
    cmp({tag, ".wb"},   32'(o_WB_control),   32'(e.wb));
    cmp({tag, ".pc"},   o_pc,                e.pc);
    cmp({tag, ".a"},    o_data_a,            e.a);
    cmp({tag, ".b"},    o_data_b,            e.b);
    cmp({tag, ".imm"},  o_immediate,         e.imm);
    cmp({tag, ".rs"},   32'(o_rs),           32'(e.rs));
    cmp({tag, ".rt"},   32'(o_rt),           32'(e.rt));
    cmp({tag, ".rd"},   32'(o_rd),           32'(e.rd));
    cmp({tag, ".sh"},   32'(o_shamt),        32'(e.sh));
    cmp({tag, ".pend"}, 32'(o_halt_pending), 32'(e.pend));
    cmp({tag, ".hlt"},  32'(o_halted),       32'(e.hlt));
  endtask

  // Drives one vector shortly after an edge, then returns 1 time unit past
  // the next rising edge, so outputs can be sampled away from the edge.
  task automatic applyStimulus(in_t v);
    i_enable        = v.en;
    i_flush         = v.fl;
    i_halt_detected = v.ht;
    i_EX_control    = v.ex;
    i_M_control     = v.m;
    i_WB_control    = v.wb;
    i_pc            = v.pc;
    i_data_a        = v.a;
    i_data_b        = v.b;
    i_immediate     = v.imm;
    i_rs            = v.rs;
    i_rt            = v.rt;
    i_rd            = v.rd;
    i_shamt         = v.sh;
    @(posedge i_clock);
    #1;
  endtask

  // Asynchronous reset pulse in mid-cycle. The outputs must clear before
  // any clock edge arrives.
  task automatic doReset(string tag);
    i_reset = 1'b1;
    #2;
    checkOutput(tag, '0);
    i_reset = 1'b0;
    modelReset();
  endtask

  initial begin
    vec_t tbl[$];
    in_t  r;
    in_t  held;
    in_t  ld;

    i_reset = 1'b1;
    applyStimulus(mkIn(0, 0, 0, 7'h0, 6'h0, 3'h0, 32'h0, 5'h0));
    checkOutput("reset", '0);
    i_reset = 1'b0;
    modelReset();

    // Capture, hold, flush, flush-beats-halt and a halt drain with a stall.
    held = mkIn(1, 0, 0, 7'h5A, 6'h00, 3'b101, 32'h1234, 5'd3);
    tbl.push_back('{held, expOf(held, 1, 0, 0)});
    r = mkIn(0, 0, 0, 7'h11, 6'h03, 3'b001, 32'h9999, 5'd9);
    tbl.push_back('{r, expOf(held, 1, 0, 0)});
    r = mkIn(0, 1, 0, 7'h22, 6'h0C, 3'b010, 32'hAAAA, 5'd10);
    tbl.push_back('{r, expOf(held, 1, 0, 0)});
    r = mkIn(0, 0, 1, 7'h7F, 6'h3F, 3'b111, 32'hFFFF_FFFF, 5'd31);
    tbl.push_back('{r, expOf(held, 1, 0, 0)});
    ld = mkIn(1, 1, 0, 7'h33, 6'h21, 3'b011, 32'h5555, 5'd7);
    tbl.push_back('{ld, expOf(ld, 0, 0, 0)});
    ld.fl = 1'b0;
    tbl.push_back('{ld, expOf(ld, 1, 0, 0)});
    r = mkIn(1, 1, 1, 7'h44, 6'h22, 3'b110, 32'h7777, 5'd12);
    tbl.push_back('{r, expOf(r, 0, 0, 0)});
    r = mkIn(1, 0, 1, 7'h44, 6'h22, 3'b110, 32'h7777, 5'd12);
    tbl.push_back('{r, expOf(r, 0, 1, 0)});
    r = mkIn(1, 0, 0, 7'h55, 6'h10, 3'b100, 32'h8888, 5'd13);
    tbl.push_back('{r, expOf(r, 0, 1, 0)});
    r = mkIn(0, 0, 0, 7'h56, 6'h11, 3'b100, 32'h8889, 5'd14);
    tbl.push_back('{r, expOf(r, 0, 1, 0)});
    r = mkIn(1, 0, 0, 7'h57, 6'h12, 3'b100, 32'h888A, 5'd15);
    tbl.push_back('{r, expOf(r, 0, 1, 0)});
    r = mkIn(1, 0, 0, 7'h58, 6'h13, 3'b100, 32'h888B, 5'd16);
    tbl.push_back('{r, expOf(r, 0, 1, 1)});
    r = mkIn(1, 0, 0, 7'h66, 6'h21, 3'b101, 32'h4321, 5'd17);
    tbl.push_back('{r, expOf(r, 0, 1, 1)});

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].in);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset while halted; then an async reset mid-cycle with outputs non-zero.
    doReset("rstHalted");
    r = mkIn(1, 0, 0, 7'h2B, 6'h05, 3'b011, 32'hCAFE, 5'd21);
    applyStimulus(r);
    checkOutput("preRst", expOf(r, 1, 0, 0));
    doReset("rstAsync");

    // Reset after H+1 of a drain, then a lw (opcode 35) captures normally.
    applyStimulus(mkIn(1, 0, 1, 7'h01, 6'h01, 3'b001, 32'h1, 5'd1));
    checkOutput("drainH", expOf(r, 0, 1, 0));
    applyStimulus(mkIn(1, 0, 0, 7'h02, 6'h02, 3'b010, 32'h2, 5'd2));
    checkOutput("drainH1", expOf(r, 0, 1, 0));
    doReset("rstDrain");
    r = mkIn(1, 0, 0, 7'h23, 6'h21, 3'b011, 32'h0000_0023, 5'd8);
    applyStimulus(r);
    checkOutput("lwAfterRst", expOf(r, 1, 0, 0));
    mdl = expOf(r, 1, 0, 0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if (mHalt && ($urandom_range(0, 3) == 0)) begin
        doReset("rndRst");
      end
      r = randIn();
      applyStimulus(r);
      modelEdge(r);
      checkOutput($sformatf("rnd%0d", n), mdl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
